issue_unit_scheduler: RTL

Per-cycle issue arbiter for the integer back end. Takes the ready flags of the four issue queues (integer ALU, multiplier, divider, load/store) and grants at most one issue per cycle. The grant is returned to the selected queue as its `issueblk_done`. The block reserves the common data bus (CDB) slot for each grant at issue time, so unit results never collide on the CDB. It also tracks the non-pipelined divider and drives the CDB source select.

---
 rtl/issue_pkg.sv | 22 ++
 rtl/rr_arbiter4.sv | 26 ++
 rtl/issue_unit_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared definitions for the integer back-end issue scheduler.
// Unit IDs, the CDB reservation entry type and default unit latencies.
// No logic here; imported by the scheduler and its arbiter.
package issue_pkg;

  localparam logic [1:0] UNIT_INT = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_DIV = 2'd2;
  localparam logic [1:0] UNIT_LS  = 2'd3;

  localparam int DEF_INT_LAT = 1;
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_LS_LAT  = 3;
  localparam int DEF_DIV_LAT = 7;

  // One CDB cycle: whether it is claimed and by which unit.
  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } rsv_entry_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin picker: first eligible requester after last_grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a zero eligible vector simply yields a zero grant.
module rr_arbiter4 (
  input  logic [3:0] eligible,
  input  logic [1:0] last_grant,
  output logic [3:0] grant
);

  // Walk the four slots starting just after the previous winner; first hit wins.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    grant = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last_grant + 2'(k + 1);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_unit_scheduler.sv
// Per-cycle issue arbiter that pre-books the CDB slot of every grant.
// Latency: grant is combinational in the request cycle; CDB select appears L_u cycles later.
// Backpressure: a queue is held off (no grant) while its CDB slot or the divider is taken.
// Optional ISSUE_SCHED_FLUSH_EN adds a flush input that kills grants and clears all state.
module issue_unit_scheduler
  import issue_pkg::*;
#(
  parameter int INT_LAT = DEF_INT_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int LS_LAT  = DEF_LS_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef ISSUE_SCHED_FLUSH_EN
  input  logic       flush,
`endif
  input  logic [3:0] queue_ready,
  output logic [3:0] issue_grant,
  output logic       div_busy,
  output logic       cdb_sel_valid,
  output logic [1:0] cdb_sel
);

  localparam int TBL_N = DIV_LAT + 1;
  localparam int CNT_W = $clog2(DIV_LAT + 1);

  // Entry i describes the CDB i cycles from now; entry 0 is the current cycle.
  rsv_entry_t       rsv_q [TBL_N];
  rsv_entry_t       rsv_d [TBL_N];
  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;
  logic [1:0]       last_q;
  logic [1:0]       last_d;
  logic [3:0]       elig;
  logic [3:0]       arb_grant;
  logic             flush_w;

`ifdef ISSUE_SCHED_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // A unit may issue only if its future CDB slot is free (and, for div, the divider is idle).
  always_comb begin
    elig           = 4'b0000;
    elig[UNIT_INT] = queue_ready[UNIT_INT] && !rsv_q[INT_LAT].valid;
    elig[UNIT_MUL] = queue_ready[UNIT_MUL] && !rsv_q[MUL_LAT].valid;
    elig[UNIT_DIV] = queue_ready[UNIT_DIV] && !rsv_q[DIV_LAT].valid && (div_cnt_q == '0);
    elig[UNIT_LS]  = queue_ready[UNIT_LS]  && !rsv_q[LS_LAT].valid;
  end

  rr_arbiter4 u_arb (
    .eligible   (elig),
    .last_grant (last_q),
    .grant      (arb_grant)
  );

  assign issue_grant   = (rst_n && !flush_w) ? arb_grant : 4'b0000;
  assign cdb_sel_valid = rst_n && rsv_q[0].valid;
  assign cdb_sel       = rst_n ? rsv_q[0].id : 2'd0;
  assign div_busy      = rst_n && (div_cnt_q != '0);

  // Shift the reservation table, book the winner's slot, advance pointer and divider count.
  always_comb begin
    for (int i = 0; i < TBL_N - 1; i++) begin
      rsv_d[i] = rsv_q[i + 1];
    end
    rsv_d[TBL_N-1] = '0;
    last_d         = last_q;
    div_cnt_d      = div_cnt_q;
    if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - CNT_W'(1);
    end
    // Write index is L-1 because the table shifts by one on the same edge.
    if (issue_grant[UNIT_INT]) begin
      rsv_d[INT_LAT-1] = '{valid: 1'b1, id: UNIT_INT};
      last_d           = UNIT_INT;
    end
    if (issue_grant[UNIT_MUL]) begin
      rsv_d[MUL_LAT-1] = '{valid: 1'b1, id: UNIT_MUL};
      last_d           = UNIT_MUL;
    end
    if (issue_grant[UNIT_DIV]) begin
      rsv_d[DIV_LAT-1] = '{valid: 1'b1, id: UNIT_DIV};
      last_d           = UNIT_DIV;
      div_cnt_d        = CNT_W'(DIV_LAT - 1);
    end
    if (issue_grant[UNIT_LS]) begin
      rsv_d[LS_LAT-1] = '{valid: 1'b1, id: UNIT_LS};
      last_d          = UNIT_LS;
    end
  end

  // State register; reset and flush both drop every reservation and point at ls so int goes first.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_w) begin
      for (int i = 0; i < TBL_N; i++) begin
        rsv_q[i] <= '0;
      end
      div_cnt_q <= '0;
      last_q    <= UNIT_LS;
    end else begin
      for (int i = 0; i < TBL_N; i++) begin
        rsv_q[i] <= rsv_d[i];
      end
      div_cnt_q <= div_cnt_d;
      last_q    <= last_d;
    end
  end

endmodule
